// File: rtl/spi_target.sv
// spi_target: SPI peripheral with pin synchronisers, RX/TX shift paths
// and a one-word TX holding register, all in the system clock domain.
module spi_target #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter bit                    CPOL       = 1'b1,
   parameter bit                    CPHA       = 1'b1,
   parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  SPI_clock,
   input  logic                  SPI_in,
   input  logic                  SPI_not_chip_select,
   output logic                  SPI_out,
   output logic                  SPI_out_enable,
   output logic                  in_data_valid,
   output logic [DATA_WIDTH-1:0] in_data,
   input  logic                  out_data_valid,
   input  logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_data_ready,
   output logic                  active,
   output logic                  frame_abort,
   output logic                  tx_underrun
);

   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, ACTIVE} state_e;

   state_e state_q, state_d;

   logic [2:0] sck_q, cs_q;
   logic [1:0] mosi_q;

   logic [CW-1:0]         bitcnt_q, bitcnt_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
   logic                  full_q, full_d;
   logic                  pend_q, pend_d;
   logic                  valid_q, valid_d;
   logic                  abort_q, abort_d;
   logic                  und_q, und_d;
   logic                  load;

   logic sck_rise, sck_fall, lead_edge, trail_edge;
   logic sample_edge, shift_edge;
   logic cs_fall, cs_rise, mosi_s;
   logic start, in_frame;

   // Two synchroniser stages plus one history stage for edge detection.
   // CS_n history resets low so a CS_n already low at reset release
   // does not look like a fresh falling edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sck_q  <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[1:0], SPI_clock};
         cs_q   <= {cs_q[1:0], SPI_not_chip_select};
         mosi_q <= {mosi_q[0], SPI_in};
      end
   end

   assign sck_rise    = sck_q[1] & ~sck_q[2];
   assign sck_fall    = ~sck_q[1] & sck_q[2];
   assign lead_edge   = CPOL ? sck_fall : sck_rise;
   assign trail_edge  = CPOL ? sck_rise : sck_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;
   assign cs_fall     = ~cs_q[1] & cs_q[2];
   assign cs_rise     = cs_q[1] & ~cs_q[2];
   assign mosi_s      = mosi_q[1];

   assign start    = (state_q == IDLE) & cs_fall;
   assign in_frame = (state_q == ACTIVE) & ~cs_rise;

   // Frame state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Frame state follows the synchronised chip select.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cs_fall) state_d = ACTIVE;
         ACTIVE:  if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pad enable and status follow the frame state.
   always_comb begin
      SPI_out_enable = (state_q == ACTIVE);
      active         = (state_q == ACTIVE);
   end

   // Shift, count, word hand-off and TX holding register next state.
   always_comb begin
      bitcnt_d  = bitcnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      hold_d    = hold_q;
      full_d    = full_q;
      pend_d    = pend_q;
      in_data_d = in_data_q;
      valid_d   = 1'b0;
      abort_d   = 1'b0;
      und_d     = 1'b0;
      load      = 1'b0;

      if (start) begin
         bitcnt_d = '0;
         rx_d     = '0;
         pend_d   = 1'b1;
         if (!CPHA) begin
            load   = 1'b1;
            pend_d = 1'b0;
         end
      end

      if ((state_q == ACTIVE) && cs_rise && (bitcnt_q != '0))
         abort_d = 1'b1;

      if (in_frame && sample_edge) begin
         rx_d = {rx_q[DATA_WIDTH-2:0], mosi_s};
         if (bitcnt_q == LAST) begin
            bitcnt_d  = '0;
            in_data_d = {rx_q[DATA_WIDTH-2:0], mosi_s};
            valid_d   = 1'b1;
            pend_d    = 1'b1;
         end else begin
            bitcnt_d = bitcnt_q + CW'(1);
         end
      end

      if (in_frame && shift_edge) begin
         if (pend_q) begin
            load   = 1'b1;
            pend_d = 1'b0;
         end else begin
            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
         end
      end

      // A load sees the holding register as it was before this clock.
      if (load) begin
         if (full_q) begin
            tx_d   = hold_q;
            full_d = 1'b0;
         end else begin
            tx_d  = TX_IDLE;
            und_d = 1'b1;
         end
      end

      if (out_data_valid && !full_q) begin
         hold_d = out_data;
         full_d = 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bitcnt_q  <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         hold_q    <= '0;
         full_q    <= 1'b0;
         pend_q    <= 1'b0;
         in_data_q <= '0;
         valid_q   <= 1'b0;
         abort_q   <= 1'b0;
         und_q     <= 1'b0;
      end else begin
         bitcnt_q  <= bitcnt_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         hold_q    <= hold_d;
         full_q    <= full_d;
         pend_q    <= pend_d;
         in_data_q <= in_data_d;
         valid_q   <= valid_d;
         abort_q   <= abort_d;
         und_q     <= und_d;
      end
   end

   assign SPI_out        = tx_q[DATA_WIDTH-1];
   assign in_data        = in_data_q;
   assign in_data_valid  = valid_q;
   assign out_data_ready = ~full_q;
   assign frame_abort    = abort_q;
   assign tx_underrun    = und_q;

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word length in bits (legal 4..32); MSB first on both lines.
REQ-002 Parameter CPOL, default 1, SCK idle level.
REQ-003 Parameter CPHA, default 1; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter TX_IDLE, default all-ones (DATA_WIDTH bits), word transmitted when no TX word is buffered.
REQ-005 clock  input  1  system clock, the only clock; all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; assertion clears all state immediately, release synchronous to clock.
REQ-007 SPI_clock  input  1  SCK from the controller; asynchronous.
REQ-008 SPI_in  input  1  MOSI; asynchronous.
REQ-009 SPI_not_chip_select  input  1  CS_n; asynchronous, active-low.
REQ-010 SPI_out  output  1  MISO data.
REQ-011 SPI_out_enable  output  1  high while the frame is active; tri-state control for the pad.
REQ-012 in_data_valid  output  1  one-cycle pulse: in_data holds a complete received word; no back-pressure.
REQ-013 in_data  output  DATA_WIDTH  last complete received word.
REQ-014 out_data_valid  input  1  TX word offered.
REQ-015 out_data  input  DATA_WIDTH  TX word.
REQ-016 out_data_ready  output  1  TX holding register empty.
REQ-017 active  output  1  synchronised CS_n is low.
REQ-018 frame_abort  output  1  one-cycle pulse: CS_n rose with a partial word (bit count not 0).
REQ-019 tx_underrun  output  1  one-cycle pulse: TX_IDLE loaded because the holding register was empty.

Function
REQ-020 SCK, MOSI and CS_n each pass a 2-flop synchroniser plus one edge-detect flop; an edge is visible 3 clocks after the pin; clock SHALL be >= 8x SCK.
REQ-021 Leading edge = SCK rising if CPOL=0, else falling; sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
REQ-022 States IDLE and ACTIVE: IDLE->ACTIVE on synchronised CS_n falling; ACTIVE->IDLE on synchronised CS_n rising; SCK edges in IDLE are ignored.
REQ-023 On entering ACTIVE, bit counter = 0, RX shift register = 0, load_pending = 1.
REQ-024 Each sample edge in ACTIVE shifts synchronised MOSI into the RX shift register LSB and increments the bit counter.
REQ-025 Bit counter wraps from DATA_WIDTH-1 to 0; on that sample edge, in_data is updated with the complete word and in_data_valid pulses exactly one clock later.
REQ-026 in_data SHALL stay stable between in_data_valid pulses; partial words SHALL never reach in_data.
REQ-027 The TX shift register loads either the holding register (which then empties, out_data_ready high the next clock) or, if the holding register is empty, TX_IDLE with a tx_underrun pulse.
REQ-028 CPHA=0: load on the CS_n-falling detection clock, then on the first shift edge after each word-final sample edge, in place of a shift.
REQ-029 CPHA=1: load on the first shift edge of each word (load_pending set), in place of a shift; otherwise each shift edge shifts left by one.
REQ-030 SPI_out = TX shift register MSB; SPI_out_enable = 1 in ACTIVE, 0 in IDLE.
REQ-031 Holding register accepts out_data when out_data_valid and out_data_ready; out_data_ready falls the next clock.
REQ-032 Accept and load in the same clock: the accepted word stays in the holding register and the loaded word is the previous content (or TX_IDLE if empty).
REQ-033 CS_n rising with bit counter != 0: pulse frame_abort, discard the partial RX word, no in_data_valid; the holding register is untouched.
REQ-034 Sample edge and CS_n rising in the same clock: CS_n wins and the edge is ignored.

Reset
REQ-035 Reset values: state IDLE, counters 0, shift registers 0, holding register empty, out_data_ready 1, in_data 0, SPI_out 0, all pulses 0, SPI_out_enable 0, active 0.
REQ-036 Reset asserted mid-frame aborts the frame without frame_abort; after release the block waits for a fresh CS_n falling edge.

Verification
REQ-037 Mode 3, DATA_WIDTH 8: preload 0xA5, MOSI 0x3C -> MISO 0xA5, one in_data_valid, in_data 0x3C.
REQ-038 Mode 0: preload 0x81; MISO bit 7 valid before the first SCK rise -> controller reads 0x81.
REQ-039 No preload, 2-word burst -> MISO 0xFF twice, two tx_underrun pulses, two in_data_valid pulses.
REQ-040 CS_n released after 5 bits -> frame_abort once, no in_data_valid, in_data unchanged.
REQ-041 DATA_WIDTH 16, mode 1, 3 back-to-back words with refill on each out_data_ready -> all words bit-exact in both directions.
REQ-042 Reset pulsed mid-word -> outputs at REQ-035 values; next frame correct.
